csi_capture_ctrl: RTL
=====================

Name: csi_capture_ctrl

Overview:
- Frame capture sequencer between the CSI-2 packet handler and the frame-buffer write port.
- Takes the packet handler's pixel word stream plus its frame-active / frame-valid flags.
- Under software control it arms, skips N frames, captures whole frames only into a ping-pong buffer, and reports completion and errors.
- Never captures a partial frame; the CSI stream cannot be stalled, so buffer backpressure is reported, never propagated upstream.

Parameters:
- DATA_W, 16, pixel word width (matches packet handler dout).
- ADDR_W, 20, word address width per buffer half.
- SKIP_W, 4, width of skip-frame count.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  single-cycle arm request; ignored while busy=1.
- cfg_abort  in  1  single-cycle abort; returns to IDLE next cycle.
- cfg_continuous  in  1  1 = re-arm automatically after each frame; sampled at start.
- cfg_skip  in  SKIP_W  frames to discard before the first capture; sampled at start.
- cfg_frame_words  in  ADDR_W  expected words per frame; sampled at start; 0 is treated as 1.
- pix_data  in  DATA_W  pixel word from the packet handler.
- pix_valid  in  1  pix_data valid (packet handler fr_valid).
- frame_active  in  1  high from frame start to frame end (packet handler fr_active).
- wr_ready  in  1  frame buffer can accept a write this cycle.
- wr_en  out  1  buffer write strobe.
- wr_addr  out  ADDR_W+1  {buf_sel, word index}.
- wr_data  out  DATA_W  registered pix_data.
- busy  out  1  state != IDLE.
- frame_done  out  1  one-cycle pulse per captured frame.
- buf_last  out  1  buffer half holding the most recent complete frame.
- frame_cnt  out  8  captured frames since start; wraps 255->0.
- err_overflow  out  1  sticky; pixel lost because wr_ready=0.
- err_size  out  1  sticky; last frame word count != cfg_frame_words.

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE, buf_sel 0.
  - Internal frame_active_q = 1, so a frame already in flight at reset release is never treated as a frame start.
- Edge detection: fs = frame_active & ~frame_active_q; fe = ~frame_active & frame_active_q.
- FSM states:
  - IDLE:
    - On cfg_start, latch cfg_*, clear err_* and frame_cnt, skip_cnt = cfg_skip.
    - Go to WAIT_FS.
  - WAIT_FS:
    - On fs with skip_cnt != 0, go to SKIP.
    - On fs with skip_cnt = 0, go to CAPTURE with word index 0.
  - SKIP:
    - Data ignored.
    - On fe, skip_cnt--, go to WAIT_FS.
  - CAPTURE:
    - Each pix_valid cycle with index < frame_words: wr_en=1 next cycle with wr_data=pix_data and wr_addr={buf_sel,index}; then index++.
    - Words at index >= frame_words are dropped and set err_size.
    - If wr_ready=0 while a write is due: word dropped, index still increments, err_overflow set.
    - On fe: err_size |= (index != frame_words); go to DONE.
  - DONE (1 cycle):
    - frame_done=1, buf_last=buf_sel, buf_sel toggles, frame_cnt++.
    - cfg_continuous=1: go to WAIT_FS. A frame starting this same cycle is missed by design; the next frame is captured.
    - cfg_continuous=0: go to IDLE.
- Write latency: pix_valid at cycle n -> wr_en at n+1. The write pipeline is 1 register deep. wr_ready is sampled at n+1 together with wr_en.
- A pix_valid arriving in the same cycle as fe is still counted and written.
- cfg_abort:
  - Takes priority over all transitions; next state is IDLE.
  - Suppresses any pending write and any frame_done.
  - Does not toggle buf_sel; err_* retained.
- cfg_start in the same cycle as cfg_abort: abort wins.
- Configuration changes while busy have no effect until the next start.

Decomposition:
- Shared package csi_pkg holds:
  - the FSM state enum (IDLE, WAIT_FS, SKIP, CAPTURE, DONE);
  - the DATA_W default, matching the packet handler width.
- One natural sub-module, csi_edge_det: registered rising/falling detector with a parameterised reset value (1 here); reusable for line-sync flags.
- The rest is flat.

Test Plan:
- Single shot: cfg_frame_words=8, skip=0, one frame of 8 valid words 0x1000..0x1007 -> 8 wr_en pulses, addr 0x00000..0x00007, one frame_done, buf_last=0, frame_cnt=1, err_*=0, busy drops.
- Arm mid-frame: start while frame_active=1 -> nothing written for that frame; the next full frame is captured at addr 0. Also assert reset while frame_active=1, release with it still high -> no capture until a fresh fs.
- Skip + continuous: skip=2, continuous=1, five frames of 4 words -> frames 1-2 discarded, frames 3,4,5 written to buf_sel 0,1,0 (addr 0x00000, 0x100000, 0x00000 bases), frame_cnt=3.
- Size error: frame_words=4, frame carries 6 words -> only 4 writes, err_size=1. A frame carrying 3 words -> 3 writes, err_size=1, frame_done still pulses.
- Backpressure: wr_ready=0 on the write for word 2 of 4 -> 3 writes at indices 0,1,3, err_overflow=1 sticky until next cfg_start.
- Abort: cfg_abort after 2 of 8 words -> IDLE next cycle, no further wr_en, no frame_done, buf_sel unchanged; a new start captures correctly.

Source files
------------

// File: rtl/csi_capture_ctrl_pkg.sv
// Shared definitions for the CSI frame capture sequencer.
package csi_pkg;

   localparam int unsigned CSI_DATA_W = 16;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_FS,
      ST_SKIP,
      ST_CAPTURE,
      ST_DONE
   } cap_state_e;

endpackage

// File: rtl/csi_capture_ctrl_if.sv
// Pixel stream in from the packet handler and write port out to the frame buffer.
interface csi_capture_ctrl_if #(
   parameter int unsigned DATA_W = csi_pkg::CSI_DATA_W,
   parameter int unsigned ADDR_W = 20
) ();

   logic [DATA_W-1:0] pix_data;
   logic              pix_valid;
   logic              frame_active;
   logic              wr_ready;
   logic              wr_en;
   logic [ADDR_W:0]   wr_addr;
   logic [DATA_W-1:0] wr_data;

   modport slave (
      input  pix_data, pix_valid, frame_active, wr_ready,
      output wr_en, wr_addr, wr_data
   );

   modport master (
      output pix_data, pix_valid, frame_active, wr_ready,
      input  wr_en, wr_addr, wr_data
   );

endinterface

// File: rtl/csi_capture_ctrl_edge_det.sv
// Registered rise/fall detector; the reset value decides what a level held through reset looks like.
module csi_edge_det #(
   parameter logic RST_VAL = 1'b1
) (
   input  logic clk,
   input  logic reset,
   input  logic sig_i,
   output logic rise_o,
   output logic fall_o
);

   logic sig_q;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) sig_q <= RST_VAL;
      else        sig_q <= sig_i;
   end

   assign rise_o = sig_i & ~sig_q;
   assign fall_o = ~sig_i & sig_q;

endmodule

// File: rtl/csi_capture_ctrl.sv
// Frame capture sequencer: arm, skip N frames, capture whole frames into a ping-pong buffer.
module csi_capture_ctrl
   import csi_pkg::*;
#(
   parameter int unsigned DATA_W = CSI_DATA_W,
   parameter int unsigned ADDR_W = 20,
   parameter int unsigned SKIP_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cfg_start,
   input  logic              cfg_abort,
   input  logic              cfg_continuous,
   input  logic [SKIP_W-1:0] cfg_skip,
   input  logic [ADDR_W-1:0] cfg_frame_words,
   csi_capture_ctrl_if.slave px,
   output logic              busy,
   output logic              frame_done,
   output logic              buf_last,
   output logic [7:0]        frame_cnt,
   output logic              err_overflow,
   output logic              err_size
);

   cap_state_e        state_q, state_d;
   logic              buf_sel_q, buf_sel_d;
   logic              buf_last_q, buf_last_d;
   logic [7:0]        frame_cnt_q, frame_cnt_d;
   logic              err_ovf_q, err_ovf_d;
   logic              err_size_q, err_size_d;
   logic              cont_q, cont_d;
   logic [SKIP_W-1:0] skip_q, skip_d;
   logic [ADDR_W-1:0] fw_q, fw_d;
   logic [ADDR_W-1:0] idx_q, idx_d;
   logic              wr_pend_q, wr_pend_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic [ADDR_W:0]   wr_addr_q, wr_addr_d;
   logic              fs, fe;

   csi_edge_det #(.RST_VAL(1'b1)) u_fa_edge (
      .clk    (clk),
      .reset  (reset),
      .sig_i  (px.frame_active),
      .rise_o (fs),
      .fall_o (fe)
   );

   always_comb begin
      state_d     = state_q;
      buf_sel_d   = buf_sel_q;
      buf_last_d  = buf_last_q;
      frame_cnt_d = frame_cnt_q;
      err_ovf_d   = err_ovf_q;
      err_size_d  = err_size_q;
      cont_d      = cont_q;
      skip_d      = skip_q;
      fw_d        = fw_q;
      idx_d       = idx_q;
      wr_pend_d   = 1'b0;
      wr_data_d   = wr_data_q;
      wr_addr_d   = wr_addr_q;
      frame_done  = 1'b0;

      // The stream cannot stall, so a refused write is lost and only flagged.
      if (wr_pend_q && !px.wr_ready) err_ovf_d = 1'b1;

      unique case (state_q)
         ST_IDLE: begin
            if (cfg_start) begin
               cont_d      = cfg_continuous;
               skip_d      = cfg_skip;
               fw_d        = (cfg_frame_words == '0) ? ADDR_W'(1) : cfg_frame_words;
               err_ovf_d   = 1'b0;
               err_size_d  = 1'b0;
               frame_cnt_d = '0;
               state_d     = ST_WAIT_FS;
            end
         end
         ST_WAIT_FS: begin
            if (fs) begin
               idx_d   = '0;
               state_d = (skip_q != '0) ? ST_SKIP : ST_CAPTURE;
            end
         end
         ST_SKIP: begin
            if (fe) begin
               skip_d  = skip_q - 1'b1;
               state_d = ST_WAIT_FS;
            end
         end
         ST_CAPTURE: begin
            if (px.pix_valid) begin
               if (idx_q < fw_q) begin
                  wr_pend_d = 1'b1;
                  wr_data_d = px.pix_data;
                  wr_addr_d = {buf_sel_q, idx_q};
                  idx_d     = idx_q + 1'b1;
               end else begin
                  err_size_d = 1'b1;
               end
            end
            if (fe) begin
               if (idx_d != fw_q) err_size_d = 1'b1;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            frame_done  = 1'b1;
            buf_last_d  = buf_sel_q;
            buf_sel_d   = ~buf_sel_q;
            frame_cnt_d = frame_cnt_q + 8'd1;
            state_d     = cont_q ? ST_WAIT_FS : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort overrides every update above, including a simultaneous start.
      if (cfg_abort) begin
         state_d     = ST_IDLE;
         wr_pend_d   = 1'b0;
         frame_done  = 1'b0;
         buf_sel_d   = buf_sel_q;
         buf_last_d  = buf_last_q;
         frame_cnt_d = frame_cnt_q;
         err_ovf_d   = err_ovf_q;
         err_size_d  = err_size_q;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         buf_sel_q   <= 1'b0;
         buf_last_q  <= 1'b0;
         frame_cnt_q <= '0;
         err_ovf_q   <= 1'b0;
         err_size_q  <= 1'b0;
         cont_q      <= 1'b0;
         skip_q      <= '0;
         fw_q        <= '0;
         idx_q       <= '0;
         wr_pend_q   <= 1'b0;
         wr_data_q   <= '0;
         wr_addr_q   <= '0;
      end else begin
         state_q     <= state_d;
         buf_sel_q   <= buf_sel_d;
         buf_last_q  <= buf_last_d;
         frame_cnt_q <= frame_cnt_d;
         err_ovf_q   <= err_ovf_d;
         err_size_q  <= err_size_d;
         cont_q      <= cont_d;
         skip_q      <= skip_d;
         fw_q        <= fw_d;
         idx_q       <= idx_d;
         wr_pend_q   <= wr_pend_d;
         wr_data_q   <= wr_data_d;
         wr_addr_q   <= wr_addr_d;
      end
   end

   assign px.wr_en      = wr_pend_q & px.wr_ready & ~cfg_abort;
   assign px.wr_addr    = wr_addr_q;
   assign px.wr_data    = wr_data_q;
   assign busy          = (state_q != ST_IDLE);
   assign buf_last      = buf_last_q;
   assign frame_cnt     = frame_cnt_q;
   assign err_overflow  = err_ovf_q;
   assign err_size      = err_size_q;

endmodule
